// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional build macro: DMEM_ALIGN_CHECK_EN (alignment checking, see dmem_responder).
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_NONE,
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;
  localparam int WORD_W = LANE_W * LANES;

  localparam logic [31:0] DMEM_BASE_ADDR_DEFAULT = 32'h1001_0000;

  // Pick the addressed byte/half out of a word and sign- or zero-extend it.
  function automatic logic [WORD_W-1:0] extend_load(logic [WORD_W-1:0] word,
                                                     logic [1:0] addr_lo,
                                                     size_e size,
                                                     logic sext);
    logic [15:0] half;
    logic [7:0]  byte_v;
    half = addr_lo[1] ? word[31:16] : word[15:0];
    case (addr_lo)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    case (size)
      SZ_WORD: return word;
      SZ_HALF: return sext ? {{16{half[15]}}, half} : {16'h0000, half};
      SZ_BYTE: return sext ? {{24{byte_v[7]}}, byte_v} : {24'h00_0000, byte_v};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_decode.sv
// Combinational decode of the CPU's size flags and low address bits into
// store byte enables, load size/extension and a misalignment indication.
module dmem_lane_decode
  import dmem_pkg::*;
(
  input  logic       sb_flag,
  input  logic       sh_flag,
  input  logic       sw_flag,
  input  logic       lb_flag,
  input  logic       lh_flag,
  input  logic       lbu_flag,
  input  logic       lhu_flag,
  input  logic       lw_flag,
  input  logic [1:0] addr_lo,
  output logic [3:0] byte_en,
  output size_e      size,
  output logic       sext,
  output logic       misaligned
);

  // Store lanes (sw > sh > sb) and load size (lw > lh > lhu > lb > lbu).
  always_comb begin
    byte_en = 4'b0000;
    if (sw_flag)      byte_en = 4'b1111;
    else if (sh_flag) byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
    else if (sb_flag) byte_en = 4'b0001 << addr_lo;

    size = SZ_NONE;
    sext = 1'b0;
    if (lw_flag) begin
      size = SZ_WORD;
    end else if (lh_flag) begin
      size = SZ_HALF;
      sext = 1'b1;
    end else if (lhu_flag) begin
      size = SZ_HALF;
    end else if (lb_flag) begin
      size = SZ_BYTE;
      sext = 1'b1;
    end else if (lbu_flag) begin
      size = SZ_BYTE;
    end

    misaligned = ((sw_flag | lw_flag) & (|addr_lo)) |
                 ((sh_flag | lh_flag | lhu_flag) & addr_lo[0]);
  end

endmodule

// File: rtl/dmem_responder.sv
// Byte-lane data RAM answering the single-cycle CPU's data-memory port.
// Writes land on the clock edge; loads are combinational so they finish in
// the same CPU cycle. After reset the array is cleared one word per enabled
// cycle while init_busy is high.
// Optional build macro: DMEM_ALIGN_CHECK_EN -- suppresses misaligned
// accesses and records the first faulting address.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR_DEFAULT,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        dm_ena,
  input  logic        dm_r,
  input  logic        dm_w,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_data_w,
  input  logic        sb_flag,
  input  logic        sh_flag,
  input  logic        sw_flag,
  input  logic        lb_flag,
  input  logic        lh_flag,
  input  logic        lbu_flag,
  input  logic        lhu_flag,
  input  logic        lw_flag,
  output logic [31:0] dm_data,
  output logic        init_busy,
  output logic        align_fault,
  output logic [31:0] fault_addr
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

  state_e            state;
  logic [AW-1:0]     init_cnt;
  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  logic [31:0]       offset;
  logic              in_range;
  logic [AW-1:0]     widx;
  logic              run;
  logic [3:0]        byte_en;
  size_e             ld_size;
  logic              ld_sext;
  logic              misaligned;
  logic              suppress;
  logic [31:0]       st_wdata;
  logic              init_we;
  logic              store_we;
  logic              load_en;

  dmem_lane_decode u_lane_decode (
    .sb_flag    (sb_flag),
    .sh_flag    (sh_flag),
    .sw_flag    (sw_flag),
    .lb_flag    (lb_flag),
    .lh_flag    (lh_flag),
    .lbu_flag   (lbu_flag),
    .lhu_flag   (lhu_flag),
    .lw_flag    (lw_flag),
    .addr_lo    (dm_addr[1:0]),
    .byte_en    (byte_en),
    .size       (ld_size),
    .sext       (ld_sext),
    .misaligned (misaligned)
  );

  // Address window check is done on the offset so the top of the window
  // never wraps past 2^32.
  assign offset   = dm_addr - BASE_ADDR;
  assign in_range = (dm_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign widx     = offset[AW+1:2];
  assign run      = (state == ST_RUN);

`ifdef DMEM_ALIGN_CHECK_EN
  assign suppress = run & dm_ena & (dm_r | dm_w) & misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign suppress          = 1'b0;
`endif

  // Narrow stores replicate their low bits so every enabled lane sees the
  // right value regardless of position.
  assign st_wdata = sw_flag ? dm_data_w :
                    sh_flag ? {2{dm_data_w[15:0]}} :
                              {4{dm_data_w[7:0]}};

  assign init_we  = ena & ~rst & (state == ST_INIT);
  assign store_we = ena & ~rst & run & dm_ena & dm_w & in_range & ~suppress;
  assign load_en  = run & dm_ena & dm_r & in_range & ~suppress;

  assign init_busy = (state == ST_INIT);
  assign dm_data   = load_en ? extend_load(mem[widx], dm_addr[1:0], ld_size, ld_sext) : '0;

  // Init sequencer: walk init_cnt over the whole array, then enter RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (ena && state == ST_INIT) begin
      if (init_cnt == AW'(DEPTH_WORDS - 1)) begin
        state <= ST_RUN;
      end else begin
        init_cnt <= init_cnt + 1'b1;
      end
    end
  end

  // Array write port: clearing during init, byte-lane stores in RUN.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_cnt] <= '0;
    end else if (store_we) begin
      for (int l = 0; l < LANES; l++) begin
        if (byte_en[l]) mem[widx][l*LANE_W +: LANE_W] <= st_wdata[l*LANE_W +: LANE_W];
      end
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  // Sticky fault flag; the address is latched only for the first fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      align_fault <= 1'b0;
      fault_addr  <= '0;
    end else if (suppress) begin
      align_fault <= 1'b1;
      if (!align_fault) fault_addr <= dm_addr;
    end
  end
`else
  assign align_fault = 1'b0;
  assign fault_addr  = '0;
`endif

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder answering the single-cycle CPU's data-memory port (dm_ena/dm_r/dm_w, dm_addr, dm_data_w and the eight sb/sh/sw/lb/lh/lbu/lhu/lw flags). It is a byte-lane RAM with synchronous writes and combinational read-back, so loads complete in the CPU's single cycle. It returns sign- or zero-extended load data on dm_data. After reset, an init state machine clears the whole array; the top level holds the CPU's ena low while init_busy is high.

## Interface
- BASE_ADDR, 32'h1001_0000, byte address of word 0
- DEPTH_WORDS, 1024, number of 32-bit words (power of two, ≥2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- ena  in  1  global enable; no write or init step when low
- dm_ena  in  1  access valid
- dm_r  in  1  read request
- dm_w  in  1  write request
- dm_addr  in  32  byte address
- dm_data_w  in  32  store data (low byte/half used for sb/sh)
- sb_flag, sh_flag, sw_flag  in  1 each  store size
- lb_flag, lh_flag, lbu_flag, lhu_flag, lw_flag  in  1 each  load size/extension
- dm_data  out  32  load data to CPU
- init_busy  out  1  array clear in progress
- align_fault  out  1  sticky misalignment flag (macro only)
- fault_addr  out  32  first faulting address (macro only)

## Operation
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Address decode:
  - in_range = BASE_ADDR ≤ dm_addr < BASE_ADDR + 4·DEPTH_WORDS.
  - Word index = (dm_addr − BASE_ADDR)[log2(DEPTH_WORDS)+1:2]; byte offset = dm_addr[1:0].
  - Byte lanes are little-endian: lane 0 = bits [7:0].
- States:
  - INIT: writes 32'h0 to word[init_cnt] each cycle that ena is high, then init_cnt++. After word DEPTH_WORDS−1, go to RUN.
  - RUN: normal service.
- Stores, in RUN at a clk edge with ena & dm_ena & dm_w & in_range:
  - sw writes all four lanes.
  - sh writes lanes {2·addr[1], 2·addr[1]+1} with dm_data_w[15:0].
  - sb writes lane addr[1:0] with dm_data_w[7:0].
  - Flag priority is sw > sh > sb. dm_w with no store flag writes nothing.
- Loads, combinational, when RUN & dm_ena & dm_r & in_range:
  - lw returns the full word.
  - lh/lhu return the halfword at addr[1], sign-/zero-extended.
  - lb/lbu return the byte at addr[1:0], sign-/zero-extended.
  - Priority is lw > lh > lhu > lb > lbu. No load flag gives 0.
- dm_data = 0 otherwise: INIT, out of range, no read, or suppressed.
- Out-of-range writes are dropped; no wrap-around.
- Read and write to the same word in the same cycle: dm_data shows the pre-edge contents; new data is visible after the edge.
- Writes are ignored in INIT.

## Timing
- Reset values: state=INIT, init_cnt=0, init_busy=1, dm_data=0, align_fault=0, fault_addr=0.
- init_busy is high for exactly DEPTH_WORDS ena-high cycles after rst deasserts, and low from the first RUN cycle.
- rst asserted mid-init restarts the count at 0. rst in RUN returns to INIT and re-clears the array.
- Store latency: 1 edge. Load latency: 0 cycles (combinational from address/flags).
- ena low freezes init_cnt and blocks writes; reads stay combinational.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - A RUN access with dm_ena & (dm_r | dm_w) is misaligned if it is sw/lw with addr[1:0] ≠ 0, or sh/lh/lhu with addr[0] ≠ 0.
  - A misaligned access is suppressed: no write, dm_data = 0.
  - At that edge, align_fault is set (sticky until rst). fault_addr captures dm_addr only when align_fault was 0.
- Not defined:
  - Low address bits are ignored for alignment (sw/lw use the word, sh/lh/lhu use addr[1]).
  - align_fault and fault_addr are tied to 0.

## Structure
- Package dmem_pkg holds:
  - access-size enum SZ_NONE/SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum ST_INIT/ST_RUN
  - lane-width constants
  - default BASE_ADDR
- One sub-module, dmem_lane_decode (combinational):
  - inputs: flags and addr[1:0]
  - outputs: 4-bit byte-enable, size, sign-extend bit, misaligned bit
- The top holds the array, the init FSM/counter and the fault registers.

## Test plan
- Reset with DEPTH_WORDS=16 → init_busy high exactly 16 cycles; then lw at every word returns 32'h0.
- sw 32'h8899_AABB @0x1001_0000 → lw=32'h8899AABB; lb@+0=32'hFFFF_FFBB; lbu@+1=32'h0000_00AA; lh@+2=32'hFFFF_8899; lhu@+2=32'h0000_8899.
- sb 32'h0000_0012 @0x1001_0003 over the previous word → lw=32'h1299_AABB; sh 32'h0000_3456 @0x1001_0000 → lw=32'h1299_3456.
- sw @0x1000_FFFC and @BASE+4·DEPTH_WORDS → memory unchanged, reads there return 0; same-edge read/write returns the old word.
- rst pulsed in RUN after writes → init_busy rises, array re-cleared, writes during INIT ignored.
- With DMEM_ALIGN_CHECK_EN: sw @0x1001_0002 → no write, align_fault=1, fault_addr=32'h1001_0002; later lh @0x1001_0005 leaves fault_addr unchanged.
